// File: rtl/cache_controller.sv
// ---------------------------------------------------------------------------
// cache_controller
//
// Sits between the MEM stage and the SRAM controller and sequences a 2-way,
// 64-row data cache.
//   - Read hits are answered in the same cycle.
//   - Read misses fetch a 64-bit line from SRAM and fill the cache.
//   - Writes go straight through to SRAM and invalidate any cached copy.
//   - `ready` is held low while an SRAM transaction is outstanding.
//
// Optional feature macro: CACHE_STATS_EN
//   defined   -> 16-bit saturating hit/miss counters are built
//   undefined -> hit_count/miss_count are tied to zero
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   address, write_data      CPU byte address and store data
//   mem_r_en, mem_w_en       CPU load/store requests (level, held while stalled)
//   read_data, ready         load result and pipeline-advance indication
//   sram_*                   request/response towards the SRAM controller
//   cache_*                  lookup/fill/invalidate interface of the cache array
//   hit_count, miss_count    statistics (zero when stats are not built)
// ---------------------------------------------------------------------------
module cache_controller #(
    parameter int ADDR_BASE = 1024,
    parameter int ADDR_LEN  = 32,
    parameter int WORD_LEN  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_LEN-1:0]   address,
    input  logic [WORD_LEN-1:0]   write_data,
    input  logic                  mem_r_en,
    input  logic                  mem_w_en,
    output logic [WORD_LEN-1:0]   read_data,
    output logic                  ready,
    output logic [ADDR_LEN-1:0]   sram_address,
    output logic [WORD_LEN-1:0]   sram_write_data,
    output logic                  sram_read_en,
    output logic                  sram_write_en,
    input  logic [2*WORD_LEN-1:0] sram_read_data,
    input  logic                  sram_ready,
    output logic [16:0]           cache_address,
    output logic [2*WORD_LEN-1:0] cache_write_data,
    output logic                  cache_read_en,
    output logic                  cache_write_en,
    output logic                  cache_invalidate,
    input  logic [WORD_LEN-1:0]   cache_read_data,
    input  logic                  cache_hit,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_MISS  = 2'd1,
        WRITE_THRU = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [ADDR_LEN-1:0] offset;
    logic                col;

    // The request is held stable by the stalled pipeline, so every address
    // derived value is purely combinational; nothing but the state is latched.
    assign offset           = address - ADDR_LEN'(ADDR_BASE);
    assign sram_address     = offset & ~ADDR_LEN'(3);
    assign cache_address    = offset[18:2];
    assign col              = offset[2];
    assign sram_write_data  = write_data;
    assign cache_write_data = sram_read_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        ready            = 1'b0;
        read_data        = '0;
        sram_read_en     = 1'b0;
        sram_write_en    = 1'b0;
        cache_read_en    = 1'b0;
        cache_write_en   = 1'b0;
        cache_invalidate = 1'b0;

        case (state_reg)
            IDLE: begin
                if (mem_w_en) begin
                    // Stores win over loads; drop any cached copy now, the
                    // SRAM write follows in WRITE_THRU.
                    cache_invalidate = 1'b1;
                    state_next       = WRITE_THRU;
                end else if (mem_r_en) begin
                    if (cache_hit) begin
                        cache_read_en = 1'b1;
                        read_data     = cache_read_data;
                        ready         = 1'b1;
                    end else begin
                        state_next = READ_MISS;
                    end
                end else begin
                    ready = 1'b1;
                end
            end

            READ_MISS: begin
                sram_read_en = 1'b1;
                if (sram_ready) begin
                    // Fill the line and forward the requested word directly
                    // from the SRAM response.
                    cache_write_en = 1'b1;
                    read_data      = col ? sram_read_data[2*WORD_LEN-1:WORD_LEN]
                                         : sram_read_data[WORD_LEN-1:0];
                    ready          = 1'b1;
                    state_next     = IDLE;
                end
            end

            WRITE_THRU: begin
                sram_write_en = 1'b1;
                if (sram_ready) begin
                    ready      = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef CACHE_STATS_EN
    logic        hit_evt;
    logic        miss_evt;
    logic [15:0] hit_count_reg;
    logic [15:0] miss_count_reg;

    assign hit_evt  = (state_reg == IDLE) && !mem_w_en && mem_r_en && cache_hit;
    assign miss_evt = (state_reg == IDLE) && !mem_w_en && mem_r_en && !cache_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            if (hit_evt && (hit_count_reg != 16'hFFFF)) begin
                hit_count_reg <= hit_count_reg + 16'd1;
            end
            if (miss_evt && (miss_count_reg != 16'hFFFF)) begin
                miss_count_reg <= miss_count_reg + 16'd1;
            end
        end
    end

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;
`else
    assign hit_count  = 16'd0;
    assign miss_count = 16'd0;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// ---------------------------------------------------------------------------
// tb_cache_controller
//
// Directed bench for cache_controller. A small behavioural SRAM (fixed
// 5-cycle wait before a 1-cycle sram_ready pulse) and a direct-mapped cache
// array stand in for the real neighbours. Each task drives one scenario and
// compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] read_data;
    logic        ready;
    logic [31:0] sram_address;
    logic [31:0] sram_write_data;
    logic        sram_read_en;
    logic        sram_write_en;
    logic [63:0] sram_read_data;
    logic        sram_ready;
    logic [16:0] cache_address;
    logic [63:0] cache_write_data;
    logic        cache_read_en;
    logic        cache_write_en;
    logic        cache_invalidate;
    logic [31:0] cache_read_data;
    logic        cache_hit;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_controller dut (
        .clk              (clk),
        .rst              (rst),
        .address          (address),
        .write_data       (write_data),
        .mem_r_en         (mem_r_en),
        .mem_w_en         (mem_w_en),
        .read_data        (read_data),
        .ready            (ready),
        .sram_address     (sram_address),
        .sram_write_data  (sram_write_data),
        .sram_read_en     (sram_read_en),
        .sram_write_en    (sram_write_en),
        .sram_read_data   (sram_read_data),
        .sram_ready       (sram_ready),
        .cache_address    (cache_address),
        .cache_write_data (cache_write_data),
        .cache_read_en    (cache_read_en),
        .cache_write_en   (cache_write_en),
        .cache_invalidate (cache_invalidate),
        .cache_read_data  (cache_read_data),
        .cache_hit        (cache_hit),
        .hit_count        (hit_count),
        .miss_count       (miss_count)
    );

    // ---------------- behavioural SRAM and cache ----------------
    logic        mdl_init;
    logic        sram_ready_mdl;
    logic        sram_ready_inj;
    logic [2:0]  lat_cnt;
    logic [63:0] sram_mem    [0:255];
    logic [63:0] cache_line  [0:255];
    logic        cache_valid [0:255];
    logic [7:0]  cidx;

    assign sram_ready      = sram_ready_mdl | sram_ready_inj;
    assign sram_read_data  = sram_mem[sram_address[10:3]];
    assign cidx            = cache_address[8:1];
    assign cache_hit       = cache_valid[cidx];
    assign cache_read_data = cache_address[0] ? cache_line[cidx][63:32]
                                              : cache_line[cidx][31:0];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt        <= 3'd0;
            sram_ready_mdl <= 1'b0;
        end else if (sram_ready_mdl) begin
            lat_cnt        <= 3'd0;
            sram_ready_mdl <= 1'b0;
        end else if (sram_read_en || sram_write_en) begin
            if (lat_cnt == 3'd4) sram_ready_mdl <= 1'b1;
            else                 lat_cnt <= lat_cnt + 3'd1;
        end else begin
            lat_cnt <= 3'd0;
        end
    end

    always @(posedge clk) begin
        if (mdl_init) begin
            for (int i = 0; i < 256; i++) begin
                sram_mem[i]    <= 64'd0;
                cache_line[i]  <= 64'd0;
                cache_valid[i] <= 1'b0;
            end
            sram_mem[0] <= 64'hBBBB_0002_AAAA_0001;
            sram_mem[2] <= 64'hDDDD_0004_CCCC_0003;
        end else begin
            if (sram_write_en && sram_ready && !rst) begin
                if (sram_address[2]) sram_mem[sram_address[10:3]][63:32] <= sram_write_data;
                else                 sram_mem[sram_address[10:3]][31:0]  <= sram_write_data;
            end
            if (cache_write_en && !rst) begin
                cache_line[cidx]  <= cache_write_data;
                cache_valid[cidx] <= 1'b1;
            end
            if (cache_invalidate && !rst) begin
                cache_valid[cidx] <= 1'b0;
            end
        end
    end

    // ---------------- transaction driver ----------------
    // Presents one request, waits (bounded) for ready, and reports what was
    // seen on the side interfaces while it was outstanding.
    logic [31:0] t_rd, t_sa;
    int t_low, t_rdc, t_wrc, t_cwe, t_cinv;

    task automatic run_txn(input logic [31:0] a, input logic [31:0] wd,
                           input logic r, input logic w);
        bit done;
        done = 0;
        t_rd = 32'd0; t_sa = 32'hFFFF_FFFF;
        t_low = 0; t_rdc = 0; t_wrc = 0; t_cwe = 0; t_cinv = 0;
        @(negedge clk);
        address = a; write_data = wd; mem_r_en = r; mem_w_en = w;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (sram_read_en)     t_rdc++;
            if (sram_write_en)    t_wrc++;
            if (cache_write_en)   t_cwe++;
            if (cache_invalidate) t_cinv++;
            if (sram_read_en || sram_write_en) t_sa = sram_address;
            if (ready) begin
                t_rd = read_data;
                done = 1;
            end else begin
                t_low++;
                @(negedge clk);
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL txn_timeout addr=%h: ready never rose within 40 cycles", a);
        end
        @(posedge clk);
        #1;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if ({sram_read_en, sram_write_en} !== 2'b00) begin errors++; $display("FAIL reset_sram_en got=%b exp=00", {sram_read_en, sram_write_en}); end
        checks++; if ({cache_read_en, cache_write_en, cache_invalidate} !== 3'b000) begin errors++; $display("FAIL reset_cache_strobes got=%b exp=000", {cache_read_en, cache_write_en, cache_invalidate}); end
        checks++; if (read_data !== 32'd0) begin errors++; $display("FAIL reset_read_data got=%h exp=0", read_data); end
        checks++; if ({hit_count, miss_count} !== 32'd0) begin errors++; $display("FAIL reset_counters got=%h/%h exp=0/0", hit_count, miss_count); end
    endtask

    task automatic test_idle();
        @(negedge clk);
        address = 32'h0000_0404;
        #1;
        checks++; if (cache_address !== 17'h00001) begin errors++; $display("FAIL idle_cache_addr got=%h exp=00001", cache_address); end
        address = 32'h0008_03FC; // offset 0x7FFFC: top of the mapped window
        #1;
        checks++; if (cache_address !== 17'h1FFFF) begin errors++; $display("FAIL max_cache_addr got=%h exp=1ffff", cache_address); end
        checks++; if (sram_address !== 32'h0007_FFFC) begin errors++; $display("FAIL max_sram_addr got=%h exp=0007fffc", sram_address); end
        // A stray sram_ready while idle must do nothing.
        @(negedge clk);
        sram_ready_inj = 1'b1;
        #1;
        checks++; if ({ready, cache_write_en, sram_read_en} !== 3'b100) begin errors++; $display("FAIL idle_stray_ready got=%b exp=100", {ready, cache_write_en, sram_read_en}); end
        @(negedge clk);
        sram_ready_inj = 1'b0;
        #1;
        checks++; if ({ready, sram_read_en, sram_write_en} !== 3'b100) begin errors++; $display("FAIL idle_after_stray got=%b exp=100", {ready, sram_read_en, sram_write_en}); end
    endtask

    task automatic test_read_miss();
        run_txn(32'h0000_0400, 32'd0, 1'b1, 1'b0);
        $display("txn read 0x400: low=%0d rd=%h cwe=%0d", t_low, t_rd, t_cwe);
        checks++; if (t_low !== 6) begin errors++; $display("FAIL miss_stall got=%0d exp=6", t_low); end
        checks++; if (t_rd !== 32'hAAAA_0001) begin errors++; $display("FAIL miss_data got=%h exp=aaaa0001", t_rd); end
        checks++; if (t_cwe !== 1) begin errors++; $display("FAIL miss_fill got=%0d exp=1", t_cwe); end
        checks++; if (t_rdc !== 6) begin errors++; $display("FAIL miss_rd_en got=%0d exp=6", t_rdc); end
        checks++; if (t_sa !== 32'h0) begin errors++; $display("FAIL miss_sram_addr got=%h exp=0", t_sa); end
    endtask

    task automatic test_read_hit();
        run_txn(32'h0000_0404, 32'd0, 1'b1, 1'b0);
        $display("txn read 0x404: low=%0d rd=%h", t_low, t_rd);
        checks++; if (t_low !== 0) begin errors++; $display("FAIL hit_stall got=%0d exp=0", t_low); end
        checks++; if (t_rd !== 32'hBBBB_0002) begin errors++; $display("FAIL hit_data got=%h exp=bbbb0002", t_rd); end
        checks++; if (t_rdc !== 0) begin errors++; $display("FAIL hit_rd_en got=%0d exp=0", t_rdc); end
    endtask

    task automatic test_write_through();
        run_txn(32'h0000_0400, 32'h0000_1234, 1'b0, 1'b1);
        $display("txn write 0x400=1234: low=%0d cinv=%0d wr=%0d", t_low, t_cinv, t_wrc);
        checks++; if (t_cinv !== 1) begin errors++; $display("FAIL wr_invalidate got=%0d exp=1", t_cinv); end
        checks++; if (t_wrc !== 6) begin errors++; $display("FAIL wr_en_cycles got=%0d exp=6", t_wrc); end
        checks++; if (t_low !== 6) begin errors++; $display("FAIL wr_stall got=%0d exp=6", t_low); end
        checks++; if (t_cwe !== 0) begin errors++; $display("FAIL wr_no_fill got=%0d exp=0", t_cwe); end
        run_txn(32'h0000_0400, 32'd0, 1'b1, 1'b0);
        $display("txn read 0x400: low=%0d rd=%h", t_low, t_rd);
        checks++; if (t_rdc !== 6) begin errors++; $display("FAIL rd_after_wr_miss got=%0d exp=6", t_rdc); end
        checks++; if (t_rd !== 32'h0000_1234) begin errors++; $display("FAIL rd_after_wr_data got=%h exp=00001234", t_rd); end
    endtask

    task automatic test_write_priority();
        run_txn(32'h0000_0408, 32'h5555_AAAA, 1'b1, 1'b1);
        $display("txn rw 0x408: rdc=%0d wrc=%0d sa=%h", t_rdc, t_wrc, t_sa);
        checks++; if (t_rdc !== 0) begin errors++; $display("FAIL prio_no_read got=%0d exp=0", t_rdc); end
        checks++; if (t_wrc !== 6) begin errors++; $display("FAIL prio_write got=%0d exp=6", t_wrc); end
        checks++; if (t_sa !== 32'h0000_0008) begin errors++; $display("FAIL prio_sram_addr got=%h exp=00000008", t_sa); end
        run_txn(32'h0000_0408, 32'd0, 1'b1, 1'b0);
        $display("txn read 0x408: low=%0d rd=%h", t_low, t_rd);
        checks++; if (t_rd !== 32'h5555_AAAA) begin errors++; $display("FAIL prio_readback got=%h exp=5555aaaa", t_rd); end
        run_txn(32'h0000_040C, 32'd0, 1'b1, 1'b0);
        $display("txn read 0x40c: low=%0d rd=%h", t_low, t_rd);
        checks++; if (t_low !== 0 || t_rd !== 32'd0) begin errors++; $display("FAIL prio_hit_col1 got=%0d/%h exp=0/00000000", t_low, t_rd); end
    endtask

    task automatic test_reset_mid_miss();
        @(negedge clk);
        address = 32'h0000_0410; mem_r_en = 1'b1;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rmid_detect got=%b exp=0", ready); end
        repeat (3) @(negedge clk);  // third READ_MISS cycle
        #1;
        checks++; if (sram_read_en !== 1'b1) begin errors++; $display("FAIL rmid_in_miss got=%b exp=1", sram_read_en); end
        rst = 1'b1; mem_r_en = 1'b0;
        #1;
        $display("txn reset mid-miss: rd_en=%b ready=%b cwe=%b", sram_read_en, ready, cache_write_en);
        checks++; if (sram_read_en !== 1'b0) begin errors++; $display("FAIL rmid_rd_en got=%b exp=0", sram_read_en); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got=%b exp=1", ready); end
        checks++; if (cache_write_en !== 1'b0) begin errors++; $display("FAIL rmid_fill got=%b exp=0", cache_write_en); end
        checks++; if ({hit_count, miss_count} !== 32'd0) begin errors++; $display("FAIL rmid_counters got=%h/%h exp=0/0", hit_count, miss_count); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_stats();
        logic [15:0] exp_hit, exp_miss;
`ifdef CACHE_STATS_EN
        exp_hit = 16'd3; exp_miss = 16'd1;
`else
        exp_hit = 16'd0; exp_miss = 16'd0;
`endif
        run_txn(32'h0000_0410, 32'd0, 1'b1, 1'b0);
        $display("txn read 0x410: low=%0d rd=%h", t_low, t_rd);
        checks++; if (t_low !== 6) begin errors++; $display("FAIL stats_miss_no_prior_fill got=%0d exp=6", t_low); end
        checks++; if (t_rd !== 32'hCCCC_0003) begin errors++; $display("FAIL stats_miss_data got=%h exp=cccc0003", t_rd); end
        run_txn(32'h0000_0414, 32'd0, 1'b1, 1'b0);
        $display("txn read 0x414: low=%0d rd=%h", t_low, t_rd);
        checks++; if (t_rd !== 32'hDDDD_0004) begin errors++; $display("FAIL stats_hit1 got=%h exp=dddd0004", t_rd); end
        run_txn(32'h0000_0410, 32'd0, 1'b1, 1'b0);
        $display("txn read 0x410: low=%0d rd=%h", t_low, t_rd);
        run_txn(32'h0000_0414, 32'd0, 1'b1, 1'b0);
        $display("txn read 0x414: low=%0d rd=%h", t_low, t_rd);
        #1;
        checks++; if (miss_count !== exp_miss) begin errors++; $display("FAIL stats_miss_count got=%0d exp=%0d", miss_count, exp_miss); end
        checks++; if (hit_count !== exp_hit) begin errors++; $display("FAIL stats_hit_count got=%0d exp=%0d", hit_count, exp_hit); end
    endtask

    initial begin
        rst = 1'b1; mdl_init = 1'b1; sram_ready_inj = 1'b0;
        address = 32'h0000_0400; write_data = 32'd0;
        mem_r_en = 1'b0; mem_w_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mdl_init = 1'b0;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_idle();
        test_read_miss();
        test_read_hit();
        test_write_through();
        test_write_priority();
        test_reset_mid_miss();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
